walk_scheduler: RTL

Wishbone master that shares one LED-walker slave between NREQ requesters.
- Each requester posts walk requests as one-cycle pulses. The scheduler counts them per requester and picks a requester round-robin.
- It issues one single-beat write to the walker to start a walk, then polls the walker's state register with reads until the walk finishes.
- Sits between the board request sources (buttons, serial command decoder) and the walker's bus port.

---
 rtl/walk_scheduler.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/walk_scheduler.sv
// walk_scheduler: Wishbone master that shares one LED-walker slave between
// NREQ requesters. Requests are counted per requester and served round-robin.
// Each walk is one start write followed by status reads until the walker
// reports idle. Optional macro WB_TIMEOUT_EN adds a bus-cycle timeout with a
// sticky o_err flag.
module walk_scheduler #(
  parameter int NREQ     = 2,
  parameter int CW       = 4,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic            o_done,
  output logic [2:0]      o_done_id,
  output logic            o_busy,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic            o_addr,
  output logic [31:0]     o_data,
  input  logic            i_stall,
  input  logic            i_ack,
  input  logic [31:0]     i_data,
  output logic            o_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WACK, S_GAP, S_RD, S_RACK} state_t;

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              done_q, done_d;
  logic [2:0]        done_id_q, done_id_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [CW-1:0]     pend_q [NREQ];
  logic [CW-1:0]     pend_d [NREQ];
  logic              hit;
  logic [PW-1:0]     sel, cand;
`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
`endif

  // Arbitration, bus sequencing and pending-count bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    grant_d   = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    hit       = 1'b0;
    sel       = '0;
    cand      = '0;
`ifdef WB_TIMEOUT_EN
    err_d     = err_q;
    tmo_d     = '0;
`endif

    // Round-robin search starting just after the last granted requester.
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!hit && pend_q[cand] != '0) begin
        hit = 1'b1;
        sel = cand;
      end
    end

    case (state_q)
      S_IDLE: if (hit) begin
        state_d      = S_WR;
        cyc_d        = 1'b1;
        stb_d        = 1'b1;
        we_d         = 1'b1;
        ptr_d        = sel;
        grant_d[sel] = 1'b1;
      end
      S_WR: if (!i_stall) begin
        stb_d   = 1'b0;
        state_d = S_WACK;
      end
      // Gap counter is loaded with POLL_GAP-1 so o_cyc stays low for exactly POLL_GAP cycles.
      S_WACK: if (i_ack) begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        gap_d   = GW'(POLL_GAP - 1);
        state_d = S_GAP;
      end
      S_GAP: if (gap_q == '0) begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b0;
        state_d = S_RD;
      end else begin
        gap_d = gap_q - 1'b1;
      end
      S_RD: if (!i_stall) begin
        stb_d   = 1'b0;
        state_d = S_RACK;
      end
      S_RACK: if (i_ack) begin
        cyc_d = 1'b0;
        if (i_data[3:0] == 4'd0) begin
          done_d    = 1'b1;
          done_id_d = 3'(ptr_q);
          state_d   = S_IDLE;
        end else begin
          gap_d   = GW'(POLL_GAP - 1);
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef WB_TIMEOUT_EN
    // Count cycles spent in one bus state; abort the cycle when the budget runs out.
    if (cyc_q && (state_q inside {S_WR, S_WACK, S_RD, S_RACK}) && state_d == state_q) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    // Request and grant in the same cycle cancel; increments saturate.
    for (int k = 0; k < NREQ; k++) begin
      pend_d[k] = pend_q[k];
      if (i_req[k] && !grant_d[k] && pend_q[k] != '1)
        pend_d[k] = pend_q[k] + 1'b1;
      else if (!i_req[k] && grant_d[k])
        pend_d[k] = pend_q[k] - 1'b1;
    end
  end

  // State and output registers; reset drops any bus cycle in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      ptr_q     <= '0;
      gap_q     <= '0;
      // NOTE: the pending-counter array is reset too; stale requests must not survive a reset.
      for (int k = 0; k < NREQ; k++) pend_q[k] <= '0;
`ifdef WB_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
`ifdef WB_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign o_grant   = grant_q;
  assign o_done    = done_q;
  assign o_done_id = done_id_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_cyc     = cyc_q;
  assign o_stb     = stb_q;
  assign o_we      = we_q;
  assign o_addr    = 1'b0;
  // The start command is only driven while the write strobe is up.
  assign o_data    = {31'd0, stb_q & we_q};

`ifdef WB_TIMEOUT_EN
  assign o_err = err_q;
  logic unused_ok;
  assign unused_ok = ^{i_data[31:4]};
`else
  assign o_err = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{i_data[31:4], (TIMEOUT != 0)};
`endif

endmodule
